// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//
// Handshake: a read request transfers on every rising edge where IMemReq and
// IMemGnt are both 1; while IMemReq is 1 and IMemGnt is 0 the requester holds
// IMemAddr stable. The requester may drop IMemReq without a grant (redirect).
// Read data comes back in request order, one word per cycle with IMemRdValid=1,
// at least one cycle after its grant, and cannot be back-pressured.
interface fetch_stage_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemGnt;
   logic        IMemRdValid;
   logic [31:0] IMemRdData;

   modport master (
      output IMemReq,
      output IMemAddr,
      input  IMemGnt,
      input  IMemRdValid,
      input  IMemRdData
   );

   modport slave (
      input  IMemReq,
      input  IMemAddr,
      output IMemGnt,
      output IMemRdValid,
      output IMemRdData
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, issues in-order reads, keeps returned
// words with their PCs in a tagged circular queue and drives the IF/ID
// register. Responses belonging to requests killed by a redirect are counted
// in disc_cnt and dropped as they return.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_stage_if.master imem,
   input  logic          StallD,
   input  logic          FlushD,
   input  logic          PCSrcE,
   input  logic [31:0]   PCTargetE,
   output logic [31:0]   InstrD,
   output logic [31:0]   PCD,
   output logic [31:0]   PCPlus4D,
   output logic          ValidD
);

   localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_X   = (CNT_W + 1)'(DEPTH);
   localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

   // Architectural and queue state
   logic [31:0]      pcf;
   logic [31:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];
   logic [DEPTH-1:0] q_filled;
   logic [PTR_W-1:0] rd_ptr, wr_ptr, fill_ptr;
   logic [CNT_W-1:0] used_cnt, unfilled_cnt, disc_cnt;

   // Next-state values of the queue bookkeeping
   logic [PTR_W-1:0] rd_ptr_nxt, wr_ptr_nxt, fill_ptr_nxt;
   logic [CNT_W-1:0] used_cnt_nxt, unfilled_cnt_nxt, disc_cnt_nxt;

   // Per-cycle events
   logic           alloc;
   logic           resp;
   logic           drop;
   logic           fill;
   logic           err_spurious;
   logic           head_filled;
   logic           pop;
   logic [CNT_W:0] occupancy;

   // The low target bits are architecturally forced to zero
   logic unused_tgt_bits;
   assign unused_tgt_bits = ^PCTargetE[1:0];

   // Entries plus discards in flight must stay below DEPTH to issue; a redirect
   // cycle never issues because PCF is about to change.
   assign occupancy     = {1'b0, used_cnt} + {1'b0, disc_cnt};
   assign imem.IMemReq  = rst_n && !PCSrcE && (occupancy < DEPTH_X);
   assign imem.IMemAddr = pcf;

   // Classify this cycle's grant, response and decode-side pop
   always_comb begin
      alloc        = imem.IMemReq && imem.IMemGnt;
      resp         = imem.IMemRdValid;
      drop         = resp && (disc_cnt != '0);
      fill         = resp && (disc_cnt == '0) && (unfilled_cnt != '0);
      err_spurious = resp && (disc_cnt == '0) && (unfilled_cnt == '0);
      head_filled  = (used_cnt != '0) && q_filled[rd_ptr];
      pop          = !PCSrcE && !FlushD && !StallD && head_filled;
   end

   // Next pointers/counters; a redirect empties the queue and converts every
   // still-unfilled entry into a pending discard
   always_comb begin
      rd_ptr_nxt       = rd_ptr;
      wr_ptr_nxt       = wr_ptr;
      fill_ptr_nxt     = fill_ptr;
      used_cnt_nxt     = used_cnt;
      unfilled_cnt_nxt = unfilled_cnt;
      disc_cnt_nxt     = disc_cnt;
      if (PCSrcE) begin
         rd_ptr_nxt       = '0;
         wr_ptr_nxt       = '0;
         fill_ptr_nxt     = '0;
         used_cnt_nxt     = '0;
         unfilled_cnt_nxt = '0;
         disc_cnt_nxt     = disc_cnt + unfilled_cnt - CNT_W'(fill) - CNT_W'(drop);
      end else begin
         rd_ptr_nxt       = rd_ptr + PTR_W'(pop);
         wr_ptr_nxt       = wr_ptr + PTR_W'(alloc);
         fill_ptr_nxt     = fill_ptr + PTR_W'(fill);
         used_cnt_nxt     = used_cnt + CNT_W'(alloc) - CNT_W'(pop);
         unfilled_cnt_nxt = unfilled_cnt + CNT_W'(alloc) - CNT_W'(fill);
         disc_cnt_nxt     = disc_cnt - CNT_W'(drop);
      end
   end

   // Register the queue bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         fill_ptr     <= '0;
         used_cnt     <= '0;
         unfilled_cnt <= '0;
         disc_cnt     <= '0;
      end else begin
         rd_ptr       <= rd_ptr_nxt;
         wr_ptr       <= wr_ptr_nxt;
         fill_ptr     <= fill_ptr_nxt;
         used_cnt     <= used_cnt_nxt;
         unfilled_cnt <= unfilled_cnt_nxt;
         disc_cnt     <= disc_cnt_nxt;
      end
   end

   // Fetch PC: redirect wins, otherwise advance by one word per grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcf <= RESET_PC;
      end else if (PCSrcE) begin
         pcf <= {PCTargetE[31:2], 2'b00};
      end else if (alloc) begin
         pcf <= pcf + 32'd4;
      end
   end

   // Entry payload: PC captured at grant, word captured at fill
   always_ff @(posedge clk) begin
      if (alloc) begin
         q_pc[wr_ptr] <= pcf;
      end
      if (fill) begin
         q_instr[fill_ptr] <= imem.IMemRdData;
      end
   end

   // Filled flags; allocation and fill never hit the same entry in one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_filled <= '0;
      end else if (PCSrcE) begin
         q_filled <= '0;
      end else begin
         if (alloc) begin
            q_filled[wr_ptr] <= 1'b0;
         end
         if (fill) begin
            q_filled[fill_ptr] <= 1'b1;
         end
      end
   end

   // IF/ID register: redirect, then flush, then stall, then pop or bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         InstrD   <= NOP_INSTR;
         PCD      <= 32'h0;
         PCPlus4D <= 32'h0;
         ValidD   <= 1'b0;
      end else if (PCSrcE || FlushD) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (!StallD) begin
         if (head_filled) begin
            InstrD   <= q_instr[rd_ptr];
            PCD      <= q_pc[rd_ptr];
            PCPlus4D <= q_pc[rd_ptr] + 32'd4;
            ValidD   <= 1'b1;
         end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end
      end
   end

   // A response with nothing to fill and nothing to discard is a memory bug
   a_no_spurious : assert property (@(posedge clk) disable iff (!rst_n) !err_spurious);

   // Queue entries plus pending discards never exceed the queue size
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) occupancy <= DEPTH_X);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed latency/stall/flush/redirect/reset steps,
// then a randomized run. A memory model answers grants in order after a
// configurable latency; a stream model checks that decode sees consecutive
// PCs from the last reset or redirect target, each with its memory word.
module tb_fetch_stage;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if imem ();
   logic        StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;

   fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .imem      (imem),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .PCSrcE    (PCSrcE),
      .PCTargetE (PCTargetE),
      .InstrD    (InstrD),
      .PCD       (PCD),
      .PCPlus4D  (PCPlus4D),
      .ValidD    (ValidD)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // ---------------- memory model ----------------
   int          mem_lat  = 1;
   int          gnt_pct  = 100;
   int          cyc      = 0;
   int          last_due = -1;
   logic [31:0] pend_addr[$];
   int          pend_due[$];

   always @(negedge rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      imem.IMemRdValid = 1'b0;
   end

   always @(posedge clk) begin
      int due;
      logic granted;
      granted = rst_n && imem.IMemReq && imem.IMemGnt;
      cyc++;
      if (granted) begin
         due = cyc - 1 + mem_lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_addr.push_back(imem.IMemAddr);
         pend_due.push_back(due);
      end
      #1;
      if (rst_n && pend_due.size() > 0 && pend_due[0] == cyc) begin
         imem.IMemRdValid = 1'b1;
         imem.IMemRdData  = mem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem.IMemRdValid = 1'b0;
         imem.IMemRdData  = $urandom;
      end
      imem.IMemGnt = ($urandom_range(0, 99) < gnt_pct);
   end

   // ---------------- stream scoreboard ----------------
   logic        pv_rst, pv_src, pv_flush, pv_stall;
   logic [31:0] pv_tgt;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] prev_instr, prev_pcd;
   logic        prev_valid;
   bit          mon_en = 1'b0;
   int          n_valid = 0;
   logic [31:0] exp_q[$];

   always @(negedge rst_n) exp_pc = RESET_PC;

   always @(posedge clk) begin
      pv_rst   = !rst_n;
      pv_src   = PCSrcE;
      pv_flush = FlushD;
      pv_stall = StallD;
      pv_tgt   = PCTargetE;
   end

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (pv_rst) begin
            chk("mon_rst_valid", ValidD, 1'b0);
            chk("mon_rst_pcd", PCD, 32'h0);
         end else if (pv_src || pv_flush) begin
            if (pv_src) exp_pc = {pv_tgt[31:2], 2'b00};
            chk("mon_bubble_valid", ValidD, 1'b0);
            chk("mon_bubble_instr", InstrD, NOP_INSTR);
            chk("mon_bubble_pcd", PCD, prev_pcd);
         end else if (pv_stall) begin
            chk("mon_hold_instr", InstrD, prev_instr);
            chk("mon_hold_pcd", PCD, prev_pcd);
            chk("mon_hold_valid", ValidD, prev_valid);
         end else if (ValidD) begin
            chk("mon_pcd", PCD, exp_pc);
            chk("mon_instr", InstrD, mem_word(exp_pc));
            chk("mon_pcplus4", PCPlus4D, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_valid++;
         end else begin
            chk("mon_idle_instr", InstrD, NOP_INSTR);
            chk("mon_idle_pcd", PCD, prev_pcd);
         end
         chk("mon_no_spurious", dut.err_spurious, 1'b0);
         prev_instr = InstrD;
         prev_pcd   = PCD;
         prev_valid = ValidD;
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed + random steps ----------------
   initial begin
      int waited;
      int base_valid;
      StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
      imem.IMemGnt = 1'b1; imem.IMemRdValid = 1'b0; imem.IMemRdData = 32'h0;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_instr", InstrD, NOP_INSTR);
      chk("rst_pcd", PCD, 32'h0);
      chk("rst_pcplus4", PCPlus4D, 32'h0);
      chk("rst_valid", ValidD, 1'b0);
      chk("rst_req", imem.IMemReq, 1'b0);
      chk("rst_addr", imem.IMemAddr, RESET_PC);

      // L=1 streaming from reset release
      for (int i = 0; i < 8; i++) exp_q.push_back(RESET_PC + 32'(4 * i));
      rst_n = 1'b1;
      #1;
      chk("s1_req_c0", imem.IMemReq, 1'b1);
      chk("s1_addr_c0", imem.IMemAddr, RESET_PC);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         chk("s1_addr", imem.IMemAddr, RESET_PC + 32'(4 * k));
         if (k < 3) begin
            chk("s1_valid_lo", ValidD, 1'b0);
         end else begin
            chk("s1_valid_hi", ValidD, 1'b1);
            chk("s1_pcd", PCD, exp_q.pop_front());
         end
      end

      // stall for 6 cycles with PCD=0x10
      StallD = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("st_pcd_hold", PCD, 32'h10);
         chk("st_valid_hold", ValidD, 1'b1);
      end
      StallD = 1'b0;
      chk("st_req_full", imem.IMemReq, 1'b0);
      chk("st_addr_full", imem.IMemAddr, 32'h24);
      @(negedge clk);
      chk("st_after_pcd0", PCD, 32'h14);
      @(negedge clk);
      chk("st_after_pcd1", PCD, 32'h18);

      // flush and stall together for one cycle
      FlushD = 1'b1; StallD = 1'b1;
      @(negedge clk);
      FlushD = 1'b0; StallD = 1'b0;
      chk("fl_instr", InstrD, NOP_INSTR);
      chk("fl_valid", ValidD, 1'b0);
      @(negedge clk);
      chk("fl_next_valid", ValidD, 1'b1);
      chk("fl_next_pcd", PCD, 32'h1C);

      // async reset mid-stream
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("ar_instr", InstrD, NOP_INSTR);
      chk("ar_pcd", PCD, 32'h0);
      chk("ar_pcplus4", PCPlus4D, 32'h0);
      chk("ar_valid", ValidD, 1'b0);
      chk("ar_req", imem.IMemReq, 1'b0);
      chk("ar_addr", imem.IMemAddr, RESET_PC);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar_restart_req", imem.IMemReq, 1'b1);
      chk("ar_restart_addr", imem.IMemAddr, RESET_PC);
      repeat (2) @(negedge clk);
      chk("ar_restart_v2", ValidD, 1'b0);
      @(negedge clk);
      chk("ar_restart_v3", ValidD, 1'b1);
      chk("ar_restart_pcd", PCD, RESET_PC);

      // L=3, two requests outstanding, redirect to 0x200
      rst_n = 1'b0;
      mem_lat = 3;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      PCSrcE = 1'b1; PCTargetE = 32'h200;
      #1;
      chk("rd_req_drop", imem.IMemReq, 1'b0);
      @(negedge clk);
      PCSrcE = 1'b0;
      chk("rd_addr", imem.IMemAddr, 32'h200);
      chk("rd_valid_lo", ValidD, 1'b0);
      chk("rd_disc", 32'(dut.disc_cnt), 32'd2);
      waited = 0;
      while (!ValidD && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("rd_wait", waited, 32'd5);
      chk("rd_pcd", PCD, 32'h200);
      chk("rd_instr", InstrD, mem_word(32'h200));

      // redirect to 0x103 while a response arrives in the same cycle
      rst_n = 1'b0;
      mem_lat = 2;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      PCSrcE = 1'b1; PCTargetE = 32'h103;
      @(negedge clk);
      PCSrcE = 1'b0;
      chk("rs_addr", imem.IMemAddr, 32'h100);
      chk("rs_disc1", 32'(dut.disc_cnt), 32'd1);
      @(negedge clk);
      chk("rs_disc0", 32'(dut.disc_cnt), 32'd0);
      waited = 0;
      while (!ValidD && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("rs_valid", ValidD, 1'b1);
      chk("rs_pcd", PCD, 32'h100);

      // randomized traffic
      base_valid = n_valid;
      gnt_pct = 60;
      for (int seg = 0; seg < 2; seg++) begin
         mem_lat = $urandom_range(1, 4);
         for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            StallD    = ($urandom_range(0, 9) < 2);
            FlushD    = ($urandom_range(0, 19) == 0);
            PCSrcE    = ($urandom_range(0, 39) == 0);
            PCTargetE = $urandom_range(0, 32'h0000_0FFF);
         end
      end
      @(negedge clk);
      StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
      repeat (12) @(negedge clk);
      chk("rnd_progress", (n_valid - base_valid > 20), 1'b1);
      chk("rnd_disc_drained", 32'(dut.disc_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
